// File: rtl/mul2_seq_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier built on one external 2x2 multiplier (MULTI2).
// Optional macro ZERO_SKIP_EN: a zero operand goes straight to DONE and skips the RUN phase.
module mul2_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [1:0]           mul_a,
    output logic [1:0]           mul_b,
    input  logic [3:0]           mul_s,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int N  = WIDTH / 2;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam int PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   i_q, j_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [PW-1:0]   prod_q;
    logic            last_pair;
    logic            j_wrap;
    logic [IW:0]     dig_sum;
    logic [PW-1:0]   pp;

    assign j_wrap    = (j_q == IW'(N - 1));
    assign last_pair = (i_q == IW'(N - 1)) && j_wrap;
    // Partial product weight is 4^(i+j), i.e. a shift of 2*(i+j) bits.
    assign dig_sum   = {1'b0, i_q} + {1'b0, j_q};
    assign pp        = PW'(mul_s) << {dig_sum, 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) begin
`ifdef ZERO_SKIP_EN
                state_d = ((a == '0) || (b == '0)) ? DONE : RUN;
`else
                state_d = RUN;
`endif
            end
            RUN:  if (last_pair) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state_q != IDLE);
        done  = (state_q == DONE);
        mul_a = 2'b00;
        mul_b = 2'b00;
        if (state_q == RUN) begin
            mul_a = a_q[{i_q, 1'b0} +: 2];
            mul_b = b_q[{j_q, 1'b0} +: 2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            i_q    <= '0;
            j_q    <= '0;
            prod_q <= '0;
        end else if (state_q == IDLE && start) begin
            a_q    <= a;
            b_q    <= b;
            i_q    <= '0;
            j_q    <= '0;
            prod_q <= '0;
        end else if (state_q == RUN) begin
            prod_q <= prod_q + pp;
            if (last_pair) begin
                i_q <= '0;
                j_q <= '0;
            end else if (j_wrap) begin
                j_q <= '0;
                i_q <= i_q + 1'b1;
            end else begin
                j_q <= j_q + 1'b1;
            end
        end
    end

    assign product = prod_q;

endmodule
